// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU opcodes and arbiter state encoding
package alu_pkg;
    localparam int DATA_W = 8;
    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
    localparam logic [OP_W-1:0] ALU_SHL = 3'b101;
    localparam logic [OP_W-1:0] ALU_SHR = 3'b110;
    localparam logic [OP_W-1:0] ALU_SLT = 3'b111;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational 8-bit ALU with zero flag
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] Y,
    output logic              zero_flag
);
    always_comb begin
        case (alu_op)
            ALU_ADD: Y = A + B;
            ALU_SUB: Y = A - B;
            ALU_AND: Y = A & B;
            ALU_OR:  Y = A | B;
            ALU_XOR: Y = A ^ B;
            ALU_SHL: Y = A << 1;
            ALU_SHR: Y = A >> 1;
            default: Y = (A < B) ? 8'd1 : 8'd0;
        endcase
    end
    assign zero_flag = (Y == '0);
endmodule

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int N = 2,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx
);
    int j;
    always_comb begin
        grant = '0;
        idx = '0;
        j = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (en && grant == '0 && req[j]) begin
                grant[j] = 1'b1;
                idx = ID_W'(j);
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between N_REQ requesters with round-robin issue
// and a single tagged response channel.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*DATA_W-1:0]  req_a,
    input  logic [N_REQ*DATA_W-1:0]  req_b,
    input  logic [N_REQ*OP_W-1:0]    req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_y,
    output logic                     rsp_zero,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);
    arb_state_t state, nxt;
    logic [ID_W-1:0] rr_ptr, id_q, gidx;
    logic [DATA_W-1:0] op_a, op_b, y;
    logic [OP_W-1:0] op_op;
    logic zero, accept;

    rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
        .req(req_valid), .ptr(rr_ptr), .en(state == IDLE), .grant(req_ready), .idx(gidx)
    );

    alu u_alu (.A(op_a), .B(op_b), .alu_op(op_op), .Y(y), .zero_flag(zero));

    // a grant bit is only ever set for a valid requester, so any grant is a handshake
    assign accept = |req_ready;
    assign busy = (state != IDLE);

    always_comb begin
        nxt = state;
        nxt = (state == IDLE) ? (accept ? EXEC : IDLE) :
              (state == EXEC) ? RESP :
              (rsp_ready ? IDLE : RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            id_q <= '0;
            op_a <= '0;
            op_b <= '0;
            op_op <= '0;
            rsp_valid <= 1'b0;
            rsp_y <= '0;
            rsp_zero <= 1'b0;
            rsp_id <= '0;
        end else begin
            if (state == IDLE && accept) begin
                op_a <= req_a[gidx*DATA_W +: DATA_W];
                op_b <= req_b[gidx*DATA_W +: DATA_W];
                op_op <= req_op[gidx*OP_W +: OP_W];
                id_q <= gidx;
                rr_ptr <= (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
            end
            if (state == EXEC) begin
                rsp_y <= y;
                rsp_zero <= zero;
                rsp_id <= id_q;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end
endmodule
